// File: rtl/dither_rgb_multimode.sv
// Multi-mode colour-depth reducer: truncation, horizontal error diffusion or 4x4 Bayer
// dithering per channel, with a single registered output stage.
module dither_rgb_multimode #(
    parameter int          CH           = 3,
    parameter int          IN_W         = 8,
    parameter int          OUT_W        = 4,
    parameter logic [1:0]  MODE_DEFAULT = 2'd1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           mode,
    input  logic                 sof,
    input  logic                 visible,
    input  logic [CH*IN_W-1:0]   pixel_in,
    output logic [CH*IN_W-1:0]   pixel_out,
    output logic                 out_valid
);

    localparam int D    = IN_W - OUT_W;
    localparam int W    = IN_W + 3;
    localparam int HALF = 1 << (D - 1);
    localparam int TSHL = (D >= 4) ? D - 4 : 0;
    localparam int TSHR = (D >= 4) ? 0 : 4 - D;

    localparam logic signed [W-1:0] MAX_IN   = W'((1 << IN_W) - 1);
    localparam logic signed [W-1:0] MAX_Q    = W'((1 << OUT_W) - 1);
    localparam logic signed [W-1:0] HALF_P   = W'(HALF);
    localparam logic signed [W-1:0] E_MAX    = W'(HALF - 1);
    localparam logic signed [W-1:0] E_MIN    = W'(-HALF);

    localparam logic [3:0] BAYER [16] = '{
        4'd0,  4'd8,  4'd2,  4'd10,
        4'd12, 4'd4,  4'd14, 4'd6,
        4'd3,  4'd11, 4'd1,  4'd9,
        4'd15, 4'd7,  4'd13, 4'd5
    };

    logic [1:0]           mode_q;
    logic [1:0]           x_q;
    logic [1:0]           y_q;
    logic [3:0]           bayer_b;
    logic [CH*IN_W-1:0]   pix_nx;

    assign bayer_b = BAYER[{y_q, x_q}];

    // out_valid doubles as the delayed visible used for line (falling edge) detection
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_DEFAULT;
            x_q       <= '0;
            y_q       <= '0;
            pixel_out <= '0;
            out_valid <= 1'b0;
        end else begin
            if (sof)
                mode_q <= mode;
            x_q <= visible ? x_q + 2'd1 : 2'd0;
            if (sof)
                y_q <= '0;
            else if (out_valid && !visible)
                y_q <= y_q + 2'd1;
            pixel_out <= visible ? pix_nx : '0;
            out_valid <= visible;
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [D:0]            err_q;
        logic signed [W-1:0]   in_v, e_v, sum_v, s_v, qe_v, en_v, t_v, qb_v;
        logic [OUT_W-1:0]      q_v;

        assign in_v = W'(pixel_in[c*IN_W +: IN_W]);
        assign e_v  = {{(W-D-1){err_q[D]}}, err_q};

        // Wide signed intermediates keep every sum and difference free of wrap-around
        always_comb begin
            sum_v = in_v + e_v;
            s_v   = sum_v;
            if (sum_v < 0)
                s_v = '0;
            else if (sum_v > MAX_IN)
                s_v = MAX_IN;

            qe_v = (s_v + HALF_P) >>> D;
            if (qe_v > MAX_Q)
                qe_v = MAX_Q;

            en_v = s_v - (qe_v <<< D);
            if (en_v > E_MAX)
                en_v = E_MAX;
            else if (en_v < E_MIN)
                en_v = E_MIN;

            t_v  = (W'(bayer_b) << TSHL) >> TSHR;
            qb_v = (in_v + t_v) >>> D;
            if (qb_v > MAX_Q)
                qb_v = MAX_Q;

            case (mode_q)
                2'd1:    q_v = qe_v[OUT_W-1:0];
                2'd2:    q_v = qb_v[OUT_W-1:0];
                default: q_v = in_v[IN_W-1:D];
            endcase
        end

        assign pix_nx[c*IN_W +: IN_W] = {q_v, {D{1'b0}}};

        always_ff @(posedge clk) begin
            if (rst || !visible || mode_q != 2'd1)
                err_q <= '0;
            else
                err_q <= en_v[D:0];
        end
    end

endmodule

// File: tb/tb_dither_rgb_multimode.sv
// Scoreboard bench for dither_rgb_multimode: directed scenarios then random traffic,
// checked against an integer reference model of the quantiser.
module tb_dither_rgb_multimode;

    localparam int CH    = 3;
    localparam int IN_W  = 8;
    localparam int OUT_W = 4;
    localparam int D     = IN_W - OUT_W;
    localparam int HALF  = 1 << (D - 1);
    localparam int MAXIN = (1 << IN_W) - 1;
    localparam int MAXQ  = (1 << OUT_W) - 1;

    logic                clk;
    logic                rst;
    logic [1:0]          mode;
    logic                sof;
    logic                visible;
    logic [CH*IN_W-1:0]  pixel_in;
    logic [CH*IN_W-1:0]  pixel_out;
    logic                out_valid;

    dither_rgb_multimode #(
        .CH(CH), .IN_W(IN_W), .OUT_W(OUT_W), .MODE_DEFAULT(2'd1)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .sof(sof), .visible(visible),
        .pixel_in(pixel_in), .pixel_out(pixel_out), .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int bayerTab [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    int  mModeQ;
    int  mX;
    int  mY;
    int  mErr [CH];
    bit  mPrevVis;

    logic [CH*IN_W:0] expQ [$];
    int vectors;
    int miscompares;

    function automatic int clampInt(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Drive one cycle of inputs and queue the response the model predicts for it
    task automatic applyStimulus(input logic r, input logic s, input logic [1:0] m,
                                 input logic v, input logic [CH*IN_W-1:0] p);
        logic [CH*IN_W-1:0] expPix;
        int inV, sv, q, t, en;
        @(negedge clk);
        rst = r; sof = s; mode = m; visible = v; pixel_in = p;
        expPix = '0;
        if (r) begin
            mModeQ = 1; mX = 0; mY = 0; mPrevVis = 0;
            for (int c = 0; c < CH; c++) mErr[c] = 0;
            expQ.push_back({1'b0, {CH*IN_W{1'b0}}});
        end else begin
            for (int c = 0; c < CH; c++) begin
                inV = int'(p[c*IN_W +: IN_W]);
                en  = 0;
                if (mModeQ == 1) begin
                    sv = clampInt(inV + mErr[c], 0, MAXIN);
                    q  = clampInt((sv + HALF) / (1 << D), 0, MAXQ);
                    en = clampInt(sv - q * (1 << D), -HALF, HALF - 1);
                end else if (mModeQ == 2) begin
                    t = (D >= 4) ? bayerTab[mY*4 + mX] * (1 << (D - 4))
                                 : bayerTab[mY*4 + mX] / (1 << (4 - D));
                    q = clampInt((inV + t) / (1 << D), 0, MAXQ);
                end else begin
                    q = inV / (1 << D);
                end
                if (v) expPix[c*IN_W +: IN_W] = IN_W'(q * (1 << D));
                mErr[c] = (v && mModeQ == 1) ? en : 0;
            end
            mX = v ? (mX + 1) % 4 : 0;
            if (s) mY = 0;
            else if (mPrevVis && !v) mY = (mY + 1) % 4;
            mPrevVis = v;
            if (s) mModeQ = int'(m);
            expQ.push_back({v, expPix});
        end
    endtask

    task automatic checkOutput(input logic [CH*IN_W:0] expected);
        vectors++;
        if ({out_valid, pixel_out} !== expected) begin
            miscompares++;
            $display("[TB] FAIL out vector %0d: got valid=%b pix=%h, expected valid=%b pix=%h",
                     vectors, out_valid, pixel_out, expected[CH*IN_W], expected[CH*IN_W-1:0]);
        end
    endtask

    initial begin
        logic [CH*IN_W:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic line(input logic s, input logic [1:0] m, input int n,
                        input logic [CH*IN_W-1:0] p);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, s && i == 0, m, 1'b1, p);
        applyStimulus(1'b0, 1'b0, m, 1'b0, '0);
    endtask

    initial begin
        logic [CH*IN_W-1:0] p;
        logic r, s, v;
        logic [1:0] m;
        vectors = 0; miscompares = 0;
        rst = 1'b1; sof = 1'b0; mode = 2'd0; visible = 1'b0; pixel_in = '0;
        mModeQ = 1; mX = 0; mY = 0; mPrevVis = 0;
        for (int c = 0; c < CH; c++) mErr[c] = 0;

        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 24'hFFFFFF);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 24'hFFFFFF);
        line(1'b0, 2'd0, 4, 24'h181818);

        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, '0);
        line(1'b0, 2'd0, 1, 24'hFF085F);

        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, '0);
        line(1'b0, 2'd1, 8, 24'h181818);
        line(1'b0, 2'd1, 8, 24'h181818);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, 24'hFFFFFF);
        line(1'b0, 2'd1, 1, 24'h000000);

        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, '0);
        line(1'b0, 2'd2, 5, 24'h080808);
        line(1'b0, 2'd2, 5, 24'h080808);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 2'd2, 1'b1, 24'h080808);
        line(1'b0, 2'd0, 3, 24'h080808);
        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, '0);
        line(1'b0, 2'd0, 4, 24'h080808);

        applyStimulus(1'b1, 1'b0, 2'd2, 1'b1, 24'h123456);
        line(1'b0, 2'd2, 3, 24'h181818);

        for (int i = 0; i < 3000; i++) begin
            r = ($urandom % 250) == 0;
            s = ($urandom % 30) == 0;
            m = 2'($urandom);
            v = ($urandom % 8) != 0;
            p = 24'($urandom);
            if ($urandom % 4 == 0) p = ($urandom % 2 == 1) ? 24'hFFFFFF : 24'h000000;
            applyStimulus(r, s, m, v, p);
        end
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, '0);

        for (int i = 0; i < 20 && expQ.size() > 0; i++) @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d responses outstanding, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
